jk_bank_seq: RTL and testbench



---
 rtl/jk_bank_seq.sv | 96 +++++++++
 tb/tb_jk_bank_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/jk_bank_seq.sv
// jk_bank_seq: valid/ready command sequencer that drives the J/K inputs of an N-bit JK bank.
// Define JK_BANK_SEQ_CHECK_EN to add the readback checker (chk_err, chk_sticky).
module jk_bank_seq #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [N-1:0]     cmd_mask,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [N-1:0]     J,
    output logic [N-1:0]     K,
    input  logic [N-1:0]     Q,
    output logic             busy,
    output logic             done
`ifdef JK_BANK_SEQ_CHECK_EN
    ,
    output logic             chk_err,
    output logic             chk_sticky
`endif
);
    typedef enum logic [1:0] {IDLE, APPLY, WAIT} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic accept;
    assign cmd_ready = state == IDLE && !Rst;
    assign accept = cmd_valid && state == IDLE;
    // op[1] selects J and op[0] selects K, so J/K are loaded straight from the command
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
            J     <= '0;
            K     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    state <= APPLY;
                    cnt   <= cmd_rep;
                    busy  <= 1'b1;
                    J     <= cmd_op[1] ? cmd_mask : '0;
                    K     <= cmd_op[0] ? cmd_mask : '0;
                end
                APPLY: if (cnt == '0) begin
                    state <= WAIT;
                    J     <= '0;
                    K     <= '0;
                    done  <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                WAIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef JK_BANK_SEQ_CHECK_EN
    logic [N-1:0] q_prev, c_mask, q_exp;
    logic [1:0]   c_op;
    logic         c_odd;
    // an odd toggle count (rep even) inverts the masked bits
    always_comb q_exp = c_op == 2'b10 ? q_prev | c_mask :
                        c_op == 2'b01 ? q_prev & ~c_mask :
                        c_op == 2'b11 ? q_prev ^ (c_odd ? '0 : c_mask) : q_prev;
    assign chk_err = done && Q != q_exp;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q_prev     <= '0;
            c_mask     <= '0;
            c_op       <= 2'b00;
            c_odd      <= 1'b0;
            chk_sticky <= 1'b0;
        end else begin
            if (accept) begin
                q_prev <= Q;
                c_mask <= cmd_mask;
                c_op   <= cmd_op;
                c_odd  <= cmd_rep[0];
            end
            if (chk_err) chk_sticky <= 1'b1;
        end
    end
`else
    logic unused_q;
    assign unused_q = ^Q;
`endif
endmodule

// File: tb/tb_jk_bank_seq.sv
// tb_jk_bank_seq: directed vector table plus hand sequences for reset, busy and checker corners.
module tb_jk_bank_seq;
    localparam int N = 8, CNT_W = 4;
    logic Clk = 1'b0, Rst = 1'b1, cmd_valid = 1'b0, cmd_ready, busy, done;
    logic [1:0] cmd_op = 2'b00;
    logic [N-1:0] cmd_mask = '0, J, K, Q, bank_q, stuck = '0, load_val = '0;
    logic load_en = 1'b0;
    logic [CNT_W-1:0] cmd_rep = '0;
    logic chk_err_w, chk_sticky_w;
    int pass_cnt = 0, total = 0;
    always #5 Clk = ~Clk;
    jk_bank_seq #(.N(N), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rep(cmd_rep),
        .J(J), .K(K), .Q(Q), .busy(busy), .done(done)
`ifdef JK_BANK_SEQ_CHECK_EN
        , .chk_err(chk_err_w), .chk_sticky(chk_sticky_w)
`endif
    );
`ifndef JK_BANK_SEQ_CHECK_EN
    assign chk_err_w = 1'b0;
    assign chk_sticky_w = 1'b0;
`endif
    // behavioural JK bank with a preload path and stuck-at-0 faults on the readback
    always @(posedge Clk) bank_q <= load_en ? load_val : (J & ~bank_q) | (~K & bank_q);
    assign Q = bank_q & ~stuck;

    typedef struct {
        logic [1:0] op;
        logic [N-1:0] mask;
        logic [CNT_W-1:0] rep;
        logic [N-1:0] q_init;
        logic [N-1:0] q_exp;
        logic hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic preload(input logic [N-1:0] v);
        @(negedge Clk);
        load_en = 1'b1;
        load_val = v;
        @(posedge Clk);
        #1 load_en = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] mask, input logic [CNT_W-1:0] rep,
                           input logic [N-1:0] q_exp, input logic hold, input logic exp_err);
        logic [N-1:0] ej, ek;
        ej = op[1] ? mask : '0;
        ek = op[0] ? mask : '0;
        @(negedge Clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_mask = mask;
        cmd_rep = rep;
        @(posedge Clk);
        #1;
        if (hold) begin
            cmd_op = ~op;
            cmd_mask = ~mask;
        end else cmd_valid = 1'b0;
        for (int i = 0; i <= int'(rep); i++) begin
            @(negedge Clk);
            chk("apply_j", J, ej);
            chk("apply_k", K, ek);
            chk("apply_busy_done_ready", {busy, done, cmd_ready}, 3'b100);
        end
        @(negedge Clk);
        chk("wait_jk", {J, K}, '0);
        chk("wait_busy_done_ready", {busy, done, cmd_ready}, 3'b110);
        chk("final_q", Q, q_exp);
`ifdef JK_BANK_SEQ_CHECK_EN
        chk("chk_err", chk_err_w, exp_err);
`endif
        cmd_valid = 1'b0;
        @(negedge Clk);
        chk("idle_busy_done_ready", {busy, done, cmd_ready}, 3'b001);
`ifdef JK_BANK_SEQ_CHECK_EN
        chk("chk_err_clear", chk_err_w, 0);
`endif
    endtask

    vec_t vecs[7];
    logic [N-1:0] q_save;
    initial begin
        vecs[0] = '{2'b10, 8'hA5, 4'd0,  8'h00, 8'hA5, 1'b0};
        vecs[1] = '{2'b01, 8'h0F, 4'd3,  8'hFF, 8'hF0, 1'b1};
        vecs[2] = '{2'b11, 8'hFF, 4'd0,  8'h3C, 8'hC3, 1'b0};
        vecs[3] = '{2'b11, 8'hFF, 4'd1,  8'hC3, 8'hC3, 1'b0};
        vecs[4] = '{2'b00, 8'hFF, 4'd15, 8'h5A, 8'h5A, 1'b0};
        vecs[5] = '{2'b10, 8'h00, 4'd2,  8'h12, 8'h12, 1'b0};
        vecs[6] = '{2'b11, 8'h0F, 4'd2,  8'h00, 8'h0F, 1'b0};
        repeat (2) @(negedge Clk);
        chk("reset_outs", {J, K, busy, done, cmd_ready}, '0);
        chk("reset_chk", {chk_err_w, chk_sticky_w}, 2'b00);
        Rst = 1'b0;
        #1 chk("ready_after_reset", cmd_ready, 1);
        foreach (vecs[i]) begin
            preload(vecs[i].q_init);
            run_cmd(vecs[i].op, vecs[i].mask, vecs[i].rep, vecs[i].q_exp, vecs[i].hold, 1'b0);
        end
        // asynchronous reset in the third APPLY cycle of a long TOGGLE
        preload(8'h00);
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_op = 2'b11;
        cmd_mask = 8'hFF;
        cmd_rep = 4'd5;
        @(posedge Clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("pre_rst_busy_j", {busy, J}, {1'b1, 8'hFF});
        q_save = Q;
        Rst = 1'b1;
        #1;
        chk("async_rst_jk", {J, K}, '0);
        chk("async_rst_busy_done", {busy, done}, 2'b00);
        repeat (2) @(negedge Clk);
        chk("rst_q_kept", Q, q_save);
        Rst = 1'b0;
        #1 chk("rst_release_ready", cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("no_done_after_rst", {busy, done}, 2'b00);
        end
        // stuck readback bit 0: checker must flag and latch, later good command keeps sticky
        preload(8'h00);
        stuck = 8'h01;
        run_cmd(2'b10, 8'h01, 4'd0, 8'h00, 1'b0, 1'b1);
`ifdef JK_BANK_SEQ_CHECK_EN
        chk("sticky_set", chk_sticky_w, 1);
`endif
        stuck = 8'h00;
        preload(8'h00);
        run_cmd(2'b10, 8'h02, 4'd1, 8'h02, 1'b0, 1'b0);
`ifdef JK_BANK_SEQ_CHECK_EN
        chk("sticky_held", chk_sticky_w, 1);
`endif
        @(negedge Clk);
        Rst = 1'b1;
        #1 chk("sticky_rst", chk_sticky_w, 0);
        @(negedge Clk);
        Rst = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
